// File: rtl/dmem_lsu_pkg.sv
// Shared types, access-size encodings and byte-enable helper for the DMEM load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_WAIT_GNT = 2'd1,
    LSU_WAIT_RSP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Halves ignore off[0] and the reserved size encoding behaves like a word.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: be_gen = 4'b0001 << off;
      SIZE_HALF: be_gen = 4'b0011 << {off[1], 1'b0};
      default:   be_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// req/gnt/rvalid data-memory bus between the load/store unit (master) and memory (slave).
interface dmem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [3:0]            bus_be_o;
  logic [31:0]           bus_wdata_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [31:0]           bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication and load extract/extend.
module dmem_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // Low address bits that do not fit the natural alignment of the size are dropped here.
  always_comb begin
    be        = be_gen(size, off);
    lane      = 2'b00;
    wdata_rep = wdata;
    case (size)
      SIZE_BYTE: begin
        wdata_rep = {4{wdata[7:0]}};
        lane      = off;
      end
      SIZE_HALF: begin
        wdata_rep = {2{wdata[15:0]}};
        lane      = {off[1], 1'b0};
      end
      default: ;
    endcase
    shifted = rdata >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: rdata_ext = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:   rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: turns core DMEM accesses into req/gnt/rvalid bus transactions with timeout.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  core_rd_en_i,
  input  logic                  core_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [31:0]           core_wdata_i,
  input  logic [1:0]            core_size_i,
  input  logic                  core_sign_i,
  output logic [31:0]           core_rdata_o,
  output logic                  stall_o,
  dmem_lsu_if.master            bus,
  output logic                  bus_err_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] misalign_addr_o
);

  localparam logic [1:0] IDLE     = LSU_IDLE;
  localparam logic [1:0] WAIT_GNT = LSU_WAIT_GNT;
  localparam logic [1:0] WAIT_RSP = LSU_WAIT_RSP;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-3:0] lat_word_q;
  logic [1:0]            lat_off_q;
  logic [1:0]            lat_size_q;
  logic                  lat_sign_q;
  logic                  lat_we_q;
  logic [31:0]           lat_wdata_q;

  logic        access, idle, busy, trap, issue, rsp_done, timeout_hit;
  logic [1:0]  sel_size, sel_off;
  logic        sel_sign;
  logic [31:0] sel_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign access   = core_rd_en_i | core_wr_en_i;
  assign idle     = (state_q == IDLE);
  assign busy     = !idle;
  assign rsp_done = (state_q == WAIT_RSP) & bus.bus_rvalid_i;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((core_size_i == SIZE_HALF) & core_addr_i[0]) |
                      (core_size_i[1] & (core_addr_i[1:0] != 2'b00));
  assign trap       = idle & access & misaligned;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)   misalign_addr_o <= '0;
    else if (trap) misalign_addr_o <= core_addr_i;
  end
`else
  assign trap            = 1'b0;
  assign misalign_addr_o = '0;
`endif

  assign issue       = idle & access & !trap;
  assign timeout_hit = TO_EN & busy & (cnt_q == CNT_LAST) & !rsp_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (issue) state_d = bus.bus_gnt_i ? WAIT_RSP : WAIT_GNT;
      WAIT_GNT: if (bus.bus_gnt_i) state_d = WAIT_RSP;
      WAIT_RSP: if (bus.bus_rvalid_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  // While waiting, the bus fields come from the latch so they stay stable whatever the core does.
  always_comb begin
    sel_size  = idle ? core_size_i       : lat_size_q;
    sel_off   = idle ? core_addr_i[1:0]  : lat_off_q;
    sel_sign  = idle ? core_sign_i       : lat_sign_q;
    sel_wdata = idle ? core_wdata_i      : lat_wdata_q;
  end

  dmem_align u_align (
    .size      (sel_size),
    .off       (sel_off),
    .sign      (sel_sign),
    .wdata     (sel_wdata),
    .rdata     (bus.bus_rdata_i),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // Everything is forced low while rst_ni is asserted, even with core inputs active.
  always_comb begin
    bus.bus_req_o   = rst_ni & (issue | (state_q == WAIT_GNT));
    bus.bus_we_o    = rst_ni & (idle ? core_wr_en_i : lat_we_q);
    bus.bus_addr_o  = rst_ni ? {(idle ? core_addr_i[ADDR_WIDTH-1:2] : lat_word_q), 2'b00} : '0;
    bus.bus_be_o    = rst_ni ? al_be : 4'b0000;
    bus.bus_wdata_o = rst_ni ? al_wdata : 32'h0;
    stall_o         = rst_ni & !timeout_hit &
                      (issue | (state_q == WAIT_GNT) | ((state_q == WAIT_RSP) & !bus.bus_rvalid_i));
    bus_err_o       = rst_ni & timeout_hit;
    misalign_o      = rst_ni & trap;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_word_q   <= '0;
      lat_off_q    <= 2'b00;
      lat_size_q   <= 2'b00;
      lat_sign_q   <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_wdata_q  <= 32'h0;
      core_rdata_o <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= busy ? cnt_q + 1'b1 : '0;
      if (issue) begin
        lat_word_q  <= core_addr_i[ADDR_WIDTH-1:2];
        lat_off_q   <= core_addr_i[1:0];
        lat_size_q  <= core_size_i;
        lat_sign_q  <= core_sign_i;
        lat_we_q    <= core_wr_en_i;
        lat_wdata_q <= core_wdata_i;
      end
      if (rsp_done && !lat_we_q)         core_rdata_o <= al_rdata;
      else if (timeout_hit && !lat_we_q) core_rdata_o <= 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (TIMEOUT_CYCLES=4); honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        core_rd_en, core_wr_en, core_sign;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [1:0]  core_size;
  logic        stall, bus_err, misalign;
  logic [31:0] misalign_addr;
  int          passed = 0;
  int          total  = 0;

  dmem_lsu_if #(.ADDR_WIDTH(32)) bus ();

  dmem_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst_ni          (rst_ni),
    .core_rd_en_i    (core_rd_en),
    .core_wr_en_i    (core_wr_en),
    .core_addr_i     (core_addr),
    .core_wdata_i    (core_wdata),
    .core_size_i     (core_size),
    .core_sign_i     (core_sign),
    .core_rdata_o    (core_rdata),
    .stall_o         (stall),
    .bus             (bus.master),
    .bus_err_o       (bus_err),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                               input logic gnt, input logic rvalid, input logic [31:0] rdata);
    core_rd_en       = rd;
    core_wr_en       = wr;
    core_addr        = addr;
    core_wdata       = wdata;
    core_size        = size;
    core_sign        = sign;
    bus.bus_gnt_i    = gnt;
    bus.bus_rvalid_i = rvalid;
    bus.bus_rdata_i  = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    // Reset with an access pending: outputs must still be quiet.
    applyStimulus(1, 0, 32'h100, 32'h0, SIZE_WORD, 0, 1, 0, 32'h0);
    checkOutput("reset_rdata", core_rdata, 32'h0);
    checkOutput("reset_req_stall_err", {29'h0, bus.bus_req_o, stall, bus_err}, 32'h0);
    checkOutput("reset_misalign", {31'h0, misalign}, 32'h0);
    idleInputs();
    #6 rst_ni = 1'b1;
    nextCycle();
    $display("[TB] word load 0x100");
    applyStimulus(1, 0, 32'h100, 32'h0, SIZE_WORD, 0, 1, 0, 32'h0);
    checkOutput("wl_req_we_be_stall", {24'h0, bus.bus_req_o, bus.bus_we_o, bus.bus_be_o, stall, 1'b0}, {24'h0, 8'b1_0_1111_1_0});
    checkOutput("wl_addr", bus.bus_addr_o, 32'h100);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'h89ABCDEF);
    checkOutput("wl_rsp_stall_req", {30'h0, stall, bus.bus_req_o}, 32'h0);
    nextCycle();
    idleInputs();
    checkOutput("wl_rdata", core_rdata, 32'h89ABCDEF);
    checkOutput("wl_idle_stall", {31'h0, stall}, 32'h0);

    $display("[TB] byte loads 0x203");
    for (int s = 1; s >= 0; s--) begin
      applyStimulus(1, 0, 32'h203, 32'h0, SIZE_BYTE, logic'(s), 1, 0, 32'h0);
      checkOutput("bl_be", {28'h0, bus.bus_be_o}, 32'h8);
      checkOutput("bl_addr", bus.bus_addr_o, 32'h200);
      nextCycle();
      applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'h80112233);
      nextCycle();
      idleInputs();
      checkOutput(s == 1 ? "bl_signed" : "bl_unsigned", core_rdata, s == 1 ? 32'hFFFFFF80 : 32'h00000080);
    end

    $display("[TB] byte store with rd and wr both set, 0x001");
    applyStimulus(1, 1, 32'h001, 32'h000000A5, SIZE_BYTE, 0, 1, 0, 32'h0);
    checkOutput("bs_we_be", {27'h0, bus.bus_we_o, bus.bus_be_o}, {27'h0, 5'b1_0010});
    checkOutput("bs_wdata", bus.bus_wdata_o, 32'hA5A5A5A5);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'hFFFFFFFF);
    nextCycle();
    idleInputs();
    checkOutput("bs_rdata_kept", core_rdata, 32'h00000080);

    $display("[TB] half store 0x42, grant after 3 cycles");
    applyStimulus(0, 1, 32'h42, 32'h0000BEEF, SIZE_HALF, 0, 0, 0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        nextCycle();
        applyStimulus(0, 0, 32'hFFC, 32'h12345678, SIZE_WORD, 1, logic'(c == 3), 0, 32'h0);
      end
      checkOutput("hs_req_we_be_stall", {25'h0, bus.bus_req_o, bus.bus_we_o, bus.bus_be_o, stall}, {25'h0, 7'b1_1_1100_1});
      checkOutput("hs_addr", bus.bus_addr_o, 32'h40);
      checkOutput("hs_wdata", bus.bus_wdata_o, 32'hBEEFBEEF);
    end
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'hCAFEF00D);
    checkOutput("hs_rsp_stall_req", {30'h0, stall, bus.bus_req_o}, 32'h0);
    nextCycle();
    idleInputs();
    checkOutput("hs_rdata_kept", core_rdata, 32'h00000080);

    $display("[TB] timeout after grant");
    applyStimulus(1, 0, 32'h300, 32'h0, SIZE_WORD, 0, 1, 0, 32'h0);
    checkOutput("to_issue_req", {31'h0, bus.bus_req_o}, 32'h1);
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      idleInputs();
      checkOutput("to_wait_err_stall", {30'h0, bus_err, stall}, 32'h1);
    end
    nextCycle();
    checkOutput("to_hit_err_stall_req", {29'h0, bus_err, stall, bus.bus_req_o}, 32'h4);
    nextCycle();
    checkOutput("to_after_err_stall_req", {29'h0, bus_err, stall, bus.bus_req_o}, 32'h0);
    checkOutput("to_rdata", core_rdata, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 1, 1, 32'h5555AAAA);
    checkOutput("stray_stall", {31'h0, stall}, 32'h0);
    nextCycle();
    idleInputs();
    checkOutput("stray_rdata", core_rdata, 32'h0);

    $display("[TB] signed half load 0x302");
    applyStimulus(1, 0, 32'h302, 32'h0, SIZE_HALF, 1, 1, 0, 32'h0);
    checkOutput("hl_be", {28'h0, bus.bus_be_o}, 32'hC);
    checkOutput("hl_addr", bus.bus_addr_o, 32'h300);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'h80017FFF);
    nextCycle();
    idleInputs();
    checkOutput("hl_rdata", core_rdata, 32'hFFFF8001);

    $display("[TB] reset while waiting for response");
    applyStimulus(1, 0, 32'h400, 32'h0, SIZE_WORD, 0, 1, 0, 32'h0);
    nextCycle();
    idleInputs();
    checkOutput("rst_pre_stall", {31'h0, stall}, 32'h1);
    #2 rst_ni = 1'b0;
    applyStimulus(1, 0, 32'h400, 32'h0, SIZE_WORD, 0, 1, 0, 32'h0);
    checkOutput("rst_req_stall", {30'h0, bus.bus_req_o, stall}, 32'h0);
    checkOutput("rst_rdata", core_rdata, 32'h0);
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'hDEADBEEF);
    rst_ni = 1'b1;
    nextCycle();
    idleInputs();
    checkOutput("rst_late_rvalid_rdata", core_rdata, 32'h0);
    checkOutput("rst_late_req_stall", {30'h0, bus.bus_req_o, stall}, 32'h0);

    $display("[TB] misaligned word load 0x105");
    applyStimulus(1, 0, 32'h105, 32'h0, SIZE_WORD, 0, 1, 0, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    checkOutput("ma_req_stall_mis", {29'h0, bus.bus_req_o, stall, misalign}, 32'h1);
    nextCycle();
    idleInputs();
    checkOutput("ma_pulse_end", {31'h0, misalign}, 32'h0);
    checkOutput("ma_addr", misalign_addr, 32'h105);
    checkOutput("ma_rdata_kept", core_rdata, 32'h0);
`else
    checkOutput("ma_req_be_mis", {26'h0, bus.bus_req_o, bus.bus_be_o, misalign}, {26'h0, 6'b1_1111_0});
    checkOutput("ma_addr", bus.bus_addr_o, 32'h104);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, SIZE_BYTE, 0, 0, 1, 32'h11223344);
    nextCycle();
    idleInputs();
    checkOutput("ma_rdata", core_rdata, 32'h11223344);
    checkOutput("ma_mis_addr_tied", misalign_addr, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly downstream of the core's DMEM interface, i.e. the rd_en/wr_en/addr/data/size/sign outputs driven from the EX-MA register.
- Converts each core access into a req/gnt/rvalid bus transaction and generates byte enables and write-lane replication.
- Returns aligned, sign- or zero-extended load data, registered for the WB stage.
- Drives stall_o into the hazard unit while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of core and bus addresses.
- TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT_GNT+WAIT_RSP before abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- core_rd_en_i  in  1  load request
- core_wr_en_i  in  1  store request
- core_addr_i  in  ADDR_WIDTH  byte address
- core_wdata_i  in  32  store data, right-justified
- core_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- core_sign_i  in  1  1 = sign-extend load
- core_rdata_o  out  32  extended load data for WB
- stall_o  out  1  freeze IF/ID/EX/MA
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated write data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  response (loads and stores)
- bus_rdata_i  in  32  read word
- bus_err_o  out  1  one-cycle pulse on timeout
- misalign_o  out  1  one-cycle misalign pulse (optional feature)
- misalign_addr_o  out  ADDR_WIDTH  faulting address (optional feature)

Behaviour:
- Reset (async, rst_ni=0): state IDLE, timeout counter 0, request latch 0, core_rdata_o=0, misalign_addr_o=0. All other outputs are 0 while in reset, including stall_o and bus_req_o.
- Access present = rd_en|wr_en. If both are high, the access is a store and bus_we_o=1.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
- IDLE with access present:
  - bus_req_o=1 combinationally, fields taken from core inputs; latch addr[1:0], size, sign and we.
  - gnt=1 -> WAIT_RSP, else -> WAIT_GNT.
- WAIT_GNT: bus_req_o=1; fields driven from the latch and held stable; gnt -> WAIT_RSP.
- WAIT_RSP: bus_req_o=0. On rvalid:
  - -> IDLE.
  - For a load, core_rdata_o <= extended data at that edge.
  - For a store, core_rdata_o is unchanged.
- stall_o = (IDLE & access present) | WAIT_GNT | (WAIT_RSP & !rvalid). It is low in the rvalid cycle so the pipeline advances on that edge. Minimum access latency is 2 cycles (gnt in issue cycle, rvalid next).
- Byte enables:
  - byte: be = 4'b0001 << addr[1:0]
  - half: be = 4'b0011 << {addr[1],1'b0}
  - word/reserved: be = 4'b1111
- Write data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = passthrough.
- Load extract: shift rdata right by 8*latched addr[1:0] (half uses addr[1] only). Sign-extend from bit 7 or 15 if sign=1, else zero-extend.
- Stray rvalid outside WAIT_RSP is ignored. gnt outside a request is ignored.
- Timeout:
  - The counter increments each cycle in WAIT_GNT/WAIT_RSP and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES-1 without completion: bus_err_o=1 for one cycle, stall_o=0, core_rdata_o <= 0 for loads, -> IDLE.
- Reset mid-transaction abandons the transaction; the bus must tolerate a dropped req.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Defined:
  - A misaligned access is not issued: bus_req_o=0, stall_o=0, state stays IDLE.
  - misalign_o=1 for exactly one cycle and misalign_addr_o <= core_addr_i.
  - core_rdata_o is unchanged.
- Undefined:
  - misalign_o and misalign_addr_o are tied 0.
  - The access is issued with offending low address bits truncated to natural alignment for be/extract.

Decomposition:
- Package lsu_pkg:
  - lsu_state_e enum
  - constants SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - function be_gen(size, off) returning [3:0]
- Sub-module dmem_align is combinational: write-lane replication, be generation and load extract/extend. It is instantiated once; the FSM, latch and timeout stay in dmem_lsu.

Test Plan:
- Word load, addr 0x100, gnt same cycle, rvalid next cycle with rdata 0x89ABCDEF -> bus_addr 0x100, be 1111; stall_o high 1 cycle; core_rdata_o=0x89ABCDEF.
- Signed byte load, addr 0x203, rdata 0x80112233 -> be 1000, core_rdata_o=0xFFFFFF80. Unsigned variant -> 0x00000080.
- Half store, addr 0x42, wdata 0x0000BEEF, gnt delayed 3 cycles -> bus_addr 0x40, be 1100, bus_wdata 0xBEEFBEEF; fields stable all 4 req cycles; stall_o low only in the rvalid cycle.
- TIMEOUT_CYCLES=4, gnt given, no rvalid -> bus_err_o pulses in 4th cycle after issue; core_rdata_o=0; FSM IDLE.
- rst_ni dropped in WAIT_RSP -> bus_req_o, stall_o and core_rdata_o 0 immediately (asynchronously); the later rvalid is ignored.
- With DMEM_MISALIGN_TRAP_EN, word load at 0x105 -> no bus_req_o, misalign_o 1 cycle, misalign_addr_o=0x105, stall_o 0. Without the macro -> bus_addr 0x104, be 1111.
